// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants: next-PC select encodings, reset PC, the NOP word and opcode nibbles.
// Imported by the fetch stage and by the decode-stage controller so both sides agree on encodings.
package fetch_stage_pkg;

   localparam logic [1:0] PCSEL_NEXT  = 2'b00;
   localparam logic [1:0] PCSEL_BR    = 2'b01;
   localparam logic [1:0] PCSEL_JAL   = 2'b10;
   localparam logic [1:0] PCSEL_STALL = 2'b11;

   localparam logic [31:0] FETCH_START_PC = 32'h0000_0040;
   localparam logic [31:0] FETCH_NOP_INST = 32'hF000_0000;

   // Opcode nibble in inst[31:28]; OP_NOP decodes to no writes and pcSel 00.
   localparam logic [3:0] OP_ALUR = 4'b1100;
   localparam logic [3:0] OP_ALUI = 4'b0100;
   localparam logic [3:0] OP_LW   = 4'b0111;
   localparam logic [3:0] OP_SW   = 4'b0011;
   localparam logic [3:0] OP_BR   = 4'b0010;
   localparam logic [3:0] OP_JAL  = 4'b0110;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [31:0] inst);
      return inst[31:28];
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold freezes all fields, squash loads the NOP word with valid low.
// One-edge latency; async active-high reset loads the NOP filler.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int unsigned               DBITS          = 32,
   parameter int unsigned               INST_BIT_WIDTH = 32,
   parameter logic [INST_BIT_WIDTH-1:0] NOP_INST       = INST_BIT_WIDTH'(FETCH_NOP_INST)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      hold,
   input  logic                      squash,
   input  logic [INST_BIT_WIDTH-1:0] inst_in,
   input  logic [DBITS-1:0]          pc_plus4_in,
   output logic [INST_BIT_WIDTH-1:0] inst_out,
   output logic [DBITS-1:0]          pc_plus4_out,
   output logic                      valid_out
);

   logic [INST_BIT_WIDTH-1:0] inst_q, inst_d;
   logic [DBITS-1:0]          pc_plus4_q, pc_plus4_d;
   logic                      valid_q, valid_d;

   always_comb begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (!hold) begin
         pc_plus4_d = pc_plus4_in;
         if (squash) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
         end else begin
            inst_d  = inst_in;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_q     <= NOP_INST;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         inst_q     <= inst_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign inst_out     = inst_q;
   assign pc_plus4_out = pc_plus4_q;
   assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux and wrong-path squash FSM feeding the IF/ID register.
// Instruction at pc appears one edge later; pcSel=11 freezes PC, IF/ID and squash counter.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned               DBITS          = 32,
   parameter int unsigned               INST_BIT_WIDTH = 32,
   parameter int unsigned               IMEM_ADDR_BITS = 11,
   parameter logic [DBITS-1:0]          START_PC       = DBITS'(FETCH_START_PC),
   parameter logic [INST_BIT_WIDTH-1:0] NOP_INST       = INST_BIT_WIDTH'(FETCH_NOP_INST),
   parameter int unsigned               FLUSH_DEPTH    = 1
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                pcSel,
   input  logic [DBITS-1:0]          brTarget,
   input  logic [DBITS-1:0]          jalTarget,
   output logic [IMEM_ADDR_BITS-1:0] imemAddr,
   input  logic [INST_BIT_WIDTH-1:0] imemData,
   output logic [DBITS-1:0]          pc,
   output logic [INST_BIT_WIDTH-1:0] instOut,
   output logic [DBITS-1:0]          pcPlus4Out,
   output logic                      validOut,
   output logic                      flushing
);

   localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);
   localparam logic [DBITS-1:0] ALIGN_MASK   = ~DBITS'(3);
   localparam logic [DBITS-1:0] PC_STEP      = DBITS'(4);

   logic [DBITS-1:0] pc_q, pc_d;
   logic [DBITS-1:0] pc_next;
   logic [DBITS-1:0] target;
   logic [1:0]       cnt_q, cnt_d;
   fetch_state_t     state_q, state_d;
   logic             redirect;
   logic             hold;
   logic             squash;

   assign pc_next  = pc_q + PC_STEP;
   assign redirect = (pcSel == PCSEL_BR) || (pcSel == PCSEL_JAL);
   assign hold     = (pcSel == PCSEL_STALL);
   assign target   = ((pcSel == PCSEL_JAL) ? jalTarget : brTarget) & ALIGN_MASK;

   // While bubbles remain the PC waits on the target so the target word is the first one delivered.
   always_comb begin
      pc_d   = pc_q;
      cnt_d  = cnt_q;
      squash = 1'b0;
      case (pcSel)
         PCSEL_STALL: ;
         PCSEL_BR, PCSEL_JAL: begin
            pc_d   = target;
            cnt_d  = FLUSH_RELOAD;
            squash = 1'b1;
         end
         default: begin
            if (state_q == ST_FLUSH) begin
               squash = 1'b1;
               cnt_d  = cnt_q - 2'd1;
            end else begin
               pc_d = pc_next;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= START_PC;
         cnt_q <= 2'd0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (redirect && (FLUSH_RELOAD != 2'd0)) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (redirect) begin
               state_d = ST_FLUSH;
            end else if ((pcSel == PCSEL_NEXT) && (cnt_q == 2'd1)) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      flushing = (state_q == ST_FLUSH);
   end

   if_id_reg #(
      .DBITS          (DBITS),
      .INST_BIT_WIDTH (INST_BIT_WIDTH),
      .NOP_INST       (NOP_INST)
   ) u_if_id (
      .clk          (clk),
      .reset        (reset),
      .hold         (hold),
      .squash       (squash),
      .inst_in      (imemData),
      .pc_plus4_in  (pc_next),
      .inst_out     (instOut),
      .pc_plus4_out (pcPlus4Out),
      .valid_out    (validOut)
   );

   assign imemAddr = pc_q[IMEM_ADDR_BITS+1:2];
   assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: one instance with a single squash slot, one with two.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] rom [0:2047];

   logic [1:0]  sel0, sel1;
   logic [31:0] br0, br1, jal0, jal1;
   logic [10:0] addr0, addr1;
   logic [31:0] data0, data1;
   logic [31:0] pc0, pc1, inst0, inst1, pp40, pp41;
   logic        vld0, vld1, fl0, fl1;

   int          npass = 0;
   int          ntotal = 0;
   bit          run_cmp = 1'b0;

   // Reference state per instance: fetch PC, IF/ID contents, bubbles still owed.
   logic [31:0] m_pc   [0:1];
   logic [31:0] m_inst [0:1];
   logic [31:0] m_pp4  [0:1];
   logic        m_vld  [0:1];
   int          m_bub  [0:1];

   always #5 clk = ~clk;

   assign data0 = rom[addr0];
   assign data1 = rom[addr1];

   fetch_stage dut0 (
      .clk(clk), .reset(reset), .pcSel(sel0), .brTarget(br0), .jalTarget(jal0),
      .imemAddr(addr0), .imemData(data0), .pc(pc0), .instOut(inst0),
      .pcPlus4Out(pp40), .validOut(vld0), .flushing(fl0)
   );

   fetch_stage #(.FLUSH_DEPTH(2)) dut1 (
      .clk(clk), .reset(reset), .pcSel(sel1), .brTarget(br1), .jalTarget(jal1),
      .imemAddr(addr1), .imemData(data1), .pc(pc1), .instOut(inst1),
      .pcPlus4Out(pp41), .validOut(vld1), .flushing(fl1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_reset(input int k);
      m_pc[k]   = 32'h40;
      m_inst[k] = NOP;
      m_pp4[k]  = 32'h0;
      m_vld[k]  = 1'b0;
      m_bub[k]  = 0;
   endtask

   task automatic model_step(input int k, input logic [1:0] s, input logic [31:0] b,
                             input logic [31:0] j, input int depth);
      logic [31:0] cur;
      cur = m_pc[k];
      if (s == 2'b01 || s == 2'b10) begin
         m_pp4[k]  = cur + 32'd4;
         m_inst[k] = NOP;
         m_vld[k]  = 1'b0;
         m_bub[k]  = depth - 1;
         m_pc[k]   = ((s == 2'b01) ? b : j) & 32'hFFFF_FFFC;
      end else if (s == 2'b00) begin
         m_pp4[k] = cur + 32'd4;
         if (m_bub[k] > 0) begin
            m_inst[k] = NOP;
            m_vld[k]  = 1'b0;
            m_bub[k]  = m_bub[k] - 1;
         end else begin
            m_inst[k] = rom[cur[12:2]];
            m_vld[k]  = 1'b1;
            m_pc[k]   = cur + 32'd4;
         end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, sel0, br0, jal0, 1);
         model_step(1, sel1, br1, jal1, 2);
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         check("d0_pc",   pc0,   m_pc[0]);
         check("d0_addr", {21'd0, addr0}, {21'd0, m_pc[0][12:2]});
         check("d0_inst", inst0, m_inst[0]);
         check("d0_pp4",  pp40,  m_pp4[0]);
         check("d0_vld",  {31'd0, vld0}, {31'd0, m_vld[0]});
         check("d0_fl",   {31'd0, fl0},  {31'd0, m_bub[0] != 0});
         check("d1_pc",   pc1,   m_pc[1]);
         check("d1_addr", {21'd0, addr1}, {21'd0, m_pc[1][12:2]});
         check("d1_inst", inst1, m_inst[1]);
         check("d1_pp4",  pp41,  m_pp4[1]);
         check("d1_vld",  {31'd0, vld1}, {31'd0, m_vld[1]});
         check("d1_fl",   {31'd0, fl1},  {31'd0, m_bub[1] != 0});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = 32'h1000_0000 + i;
      reset = 1'b1;
      sel0 = 2'b11; sel1 = 2'b11;
      br0 = '0; br1 = '0; jal0 = '0; jal1 = '0;
      tick(); tick();

      check("rst_pc",    pc0,   32'h40);
      check("rst_inst",  inst0, NOP);
      check("rst_pp4",   pp40,  32'h0);
      check("rst_vld",   {31'd0, vld0}, 32'd0);
      check("rst_fl",    {31'd0, fl1},  32'd0);
      check("rst_addr",  {21'd0, addr0}, 32'h10);
      reset = 1'b0;
      run_cmp = 1'b1;

      // Sequential fetch from 0x40
      sel0 = 2'b00; tick();
      check("seq1_pc",   pc0,   32'h44);
      check("seq1_inst", inst0, 32'h1000_0010);
      check("seq1_pp4",  pp40,  32'h44);
      check("seq1_vld",  {31'd0, vld0}, 32'd1);
      tick(); tick();
      check("seq3_inst", inst0, 32'h1000_0012);
      check("seq3_pc",   pc0,   32'h4C);

      // Two-cycle stall
      sel0 = 2'b11; tick(); tick();
      check("stall_pc",   pc0,   32'h4C);
      check("stall_inst", inst0, 32'h1000_0012);
      check("stall_pp4",  pp40,  32'h4C);
      check("stall_vld",  {31'd0, vld0}, 32'd1);
      sel0 = 2'b00; tick();
      check("resume_pc",   pc0,   32'h50);
      check("resume_inst", inst0, 32'h1000_0013);

      // Branch with unaligned target
      sel0 = 2'b01; br0 = 32'h103; tick();
      check("br_pc",   pc0,   32'h100);
      check("br_inst", inst0, NOP);
      check("br_vld",  {31'd0, vld0}, 32'd0);
      check("br_pp4",  pp40,  32'h54);
      check("br_fl",   {31'd0, fl0},  32'd0);
      sel0 = 2'b00; tick();
      check("br_tgt_inst", inst0, 32'h1000_0040);
      check("br_tgt_vld",  {31'd0, vld0}, 32'd1);

      // PC wrap through 0xFFFF_FFFC
      sel0 = 2'b10; jal0 = 32'hFFFF_FFFC; tick();
      check("wrap_pre_pc", pc0, 32'hFFFF_FFFC);
      sel0 = 2'b00; tick();
      check("wrap_pc",   pc0,   32'h0);
      check("wrap_pp4",  pp40,  32'h0);
      check("wrap_inst", inst0, 32'h1000_07FF);
      sel0 = 2'b11;

      // Two-slot flush after JAL
      sel1 = 2'b10; jal1 = 32'h200; tick();
      check("jal_pc",  pc1, 32'h200);
      check("jal_vld", {31'd0, vld1}, 32'd0);
      check("jal_fl",  {31'd0, fl1},  32'd1);
      sel1 = 2'b00; tick();
      check("jal_b2_vld", {31'd0, vld1}, 32'd0);
      check("jal_b2_fl",  {31'd0, fl1},  32'd0);
      tick();
      check("jal_tgt_inst", inst1, 32'h1000_0080);
      check("jal_tgt_vld",  {31'd0, vld1}, 32'd1);

      // Stall in the middle of the flush
      sel1 = 2'b10; jal1 = 32'h300; tick();
      sel1 = 2'b11; tick(); tick();
      check("fstall_fl",  {31'd0, fl1}, 32'd1);
      check("fstall_pc",  pc1, 32'h300);
      sel1 = 2'b00; tick();
      check("fstall_b2_fl", {31'd0, fl1}, 32'd0);
      tick();
      check("fstall_tgt", inst1, 32'h1000_00C0);

      // Redirect while flushing restarts the count
      sel1 = 2'b01; br1 = 32'h500; tick();
      sel1 = 2'b10; jal1 = 32'h601; tick();
      check("restart_pc", pc1, 32'h600);
      check("restart_fl", {31'd0, fl1}, 32'd1);
      sel1 = 2'b00; tick();
      check("restart_b2_vld", {31'd0, vld1}, 32'd0);
      tick();
      check("restart_tgt", inst1, 32'h1000_0180);

      // Asynchronous reset mid-cycle during a flush
      sel1 = 2'b10; jal1 = 32'h400; tick();
      #2 reset = 1'b1;
      #1;
      check("arst_pc",   pc1,  32'h40);
      check("arst_vld",  {31'd0, vld1}, 32'd0);
      check("arst_fl",   {31'd0, fl1},  32'd0);
      check("arst_inst", inst1, NOP);
      check("arst_pp4",  pp41,  32'h0);
      tick();
      reset = 1'b0;

      // Mixed traffic on both instances, checked by the model every cycle
      for (int i = 0; i < 24; i++) begin
         sel0 = 2'((i * 7 + 1) % 5 == 0 ? 2'b01 : ((i % 6 == 3) ? 2'b11 : 2'b00));
         sel1 = 2'((i % 7 == 2) ? 2'b10 : ((i % 5 == 4) ? 2'b11 : 2'b00));
         br0  = 32'h800 + 32'(i * 12) + 32'(i % 4);
         jal1 = 32'h1000 + 32'(i * 20) + 32'(i % 3);
         tick();
      end
      sel0 = 2'b00; sel1 = 2'b00;
      tick(); tick(); tick();

      @(negedge clk);
      run_cmp = 1'b0;
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
